pc_flow_ctrl: RTL and testbench
===============================

Name: pc_flow_ctrl

Overview:
- Program-flow sequencer that owns the 20-bit program counter.
- Each accepted op yields the next PC: increment, unconditional jump, flag-conditional jump (zero/sign/carry), call, return or halt.
- Holds a hardware return-address stack for CALL/RET.
- Sits between instruction decode and fetch; the jump evaluation formerly done per jump type is centralised here.

Parameters:
- PC_W, 20, program counter / address width.
- DEPTH, 8, return-address stack entries (power of two, ≥2).
- SP_W, 4, stack-pointer width; must satisfy 2^SP_W > DEPTH.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; in IDLE loads pc from start_addr and enters RUN.
- start_addr  in  PC_W  boot address.
- op_valid  in  1  op/flags/jmp_address valid this cycle.
- op  in  3  0 NEXT, 1 JMP, 2 JMPZ, 3 JMPS, 4 JMPC, 5 CALL, 6 RET, 7 HALT.
- zero_flag  in  1  ALU zero flag.
- sign_flag  in  1  ALU sign flag (1 = negative).
- carry_flag  in  1  ALU carry flag.
- jmp_address  in  PC_W  target address from GPR.
- op_ready  out  1  high in RUN only; op accepted when op_valid & op_ready.
- pc  out  PC_W  current program counter (registered).
- taken  out  1  one-cycle pulse: the last accepted op redirected the PC (JMP, satisfied Jcc, CALL, RET).
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT (guard build only; tied 0 otherwise).
- sp  out  SP_W  number of valid stack entries.

Behaviour:
- Reset (sync, any state, mid-operation included): state=IDLE, pc=0, sp=0, taken=0, halted=0, fault=0, op_ready=0. Stack contents need not be cleared.
- States: IDLE, RUN, HALT, FAULT.
  - IDLE --start--> RUN with pc<=start_addr. start is ignored in RUN/FAULT.
  - RUN --HALT op--> HALT. pc holds.
  - HALT --start--> RUN with pc<=start_addr. sp is preserved.
  - FAULT is exited only by rst.
- Latency: an op accepted in cycle N updates pc and taken at edge N+1. One op per cycle; no bubbles.
- No op accepted (op_valid=0 or not RUN): pc holds, taken=0.
- Op semantics (flags sampled in the accept cycle):
  - NEXT: pc<=pc+1 mod 2^PC_W. 0xFFFFF wraps to 0x00000.
  - JMP: pc<=jmp_address.
  - JMPZ / JMPS / JMPC: if the respective flag is set, pc<=jmp_address and taken=1; else pc<=pc+1 and taken=0.
  - CALL: push (pc+1 mod 2^PC_W), sp<=sp+1, pc<=jmp_address.
  - RET: pop; pc<=top entry, sp<=sp-1.
  - HALT: pc holds, taken=0.
- Stack is LIFO; the top entry is at index sp-1.
- start and op_valid in the same cycle:
  - In IDLE/HALT, start wins (op_ready=0 there).
  - In RUN, start is ignored.
- Boundary, default build:
  - CALL with sp==DEPTH: push dropped, sp stays DEPTH, jump still performed.
  - RET with sp==0: pc<=0, sp stays 0, taken=1.

Optional Feature:
- Macro: PC_FLOW_STACK_GUARD_EN.
- Defined:
  - CALL with sp==DEPTH, or RET with sp==0, sets state=FAULT at the next edge.
  - pc, sp and stack are unchanged by the offending op; fault=1, op_ready=0, taken=0.
  - Held until rst.
- Undefined: fault port tied 0, FAULT state absent, and the default drop/zero behaviour above applies.

Test Plan:
- rst, start with start_addr=0x00100, then 3 NEXT ops → pc 0x00100, 0x00101, 0x00102, 0x00103 on successive edges; taken=0 throughout.
- pc=0x00200; JMPS with sign_flag=1, jmp_address=0x0ABCD → pc=0x0ABCD, taken=1. Then JMPZ with zero_flag=0, jmp_address=0x00050 → pc=0x0ABCE, taken=0.
- pc=0x00010; CALL 0x00400, then CALL 0x00800, then RET, RET → pc 0x00400, 0x00800, 0x00401, 0x00011; sp 1, 2, 1, 0.
- Start at 0xFFFFF, NEXT → pc=0x00000. HALT → halted=1, op_ready=0, pc holds for 5 cycles with op_valid=1. start with start_addr=0x00020 → RUN, pc=0x00020.
- Fill stack with 8 CALLs then a 9th CALL to 0x01234:
  - default build: sp=8, pc=0x01234;
  - guard build: fault=1, pc unchanged.
  - RET at sp=0: default build gives pc=0x00000; guard build gives fault=1.
- Assert rst while in RUN with sp=3 and op_valid=1 → next edge: IDLE, pc=0, sp=0, taken=0, op_ready=0.

Source files
------------

// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl: program-flow sequencer that owns the program counter.
//
// Every op accepted in RUN (op_valid_i & op_ready_o) produces the next PC
// one edge later: increment, jump, flag-conditional jump, call, return or
// halt. CALL/RET use a small hardware return-address stack, LIFO, where the
// top entry sits at index sp-1.
//
// Optional build macro: PC_FLOW_STACK_GUARD_EN
//   defined   : CALL on a full stack or RET on an empty stack enters FAULT
//               (held until rst_i); the offending op changes nothing.
//   undefined : overflowing pushes are dropped (the jump still happens),
//               RET on an empty stack goes to pc 0; fault_o is tied 0.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        boot pulse, honoured in IDLE/HALT only
//   start_addr_i   boot address
//   op_valid_i     op/flags/jmp_address_i valid this cycle
//   op_i           0 NEXT 1 JMP 2 JMPZ 3 JMPS 4 JMPC 5 CALL 6 RET 7 HALT
//   zero_flag_i    ALU zero flag
//   sign_flag_i    ALU sign flag (1 = negative)
//   carry_flag_i   ALU carry flag
//   jmp_address_i  jump / call target
//   op_ready_o     high in RUN only
//   pc_o           registered program counter
//   taken_o        one-cycle pulse: last accepted op redirected the PC
//   halted_o       high in HALT
//   fault_o        high in FAULT (guard build), else 0
//   sp_o           number of valid stack entries
module pc_flow_ctrl #(
  parameter int unsigned PC_W  = 20,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SP_W  = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [PC_W-1:0] start_addr_i,
  input  logic            op_valid_i,
  input  logic [2:0]      op_i,
  input  logic            zero_flag_i,
  input  logic            sign_flag_i,
  input  logic            carry_flag_i,
  input  logic [PC_W-1:0] jmp_address_i,
  output logic            op_ready_o,
  output logic [PC_W-1:0] pc_o,
  output logic            taken_o,
  output logic            halted_o,
  output logic            fault_o,
  output logic [SP_W-1:0] sp_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JMP  = 3'd1,
    OP_JMPZ = 3'd2,
    OP_JMPS = 3'd3,
    OP_JMPC = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_HALT = 3'd7
  } op_e;

`ifdef PC_FLOW_STACK_GUARD_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;
`endif

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            taken_q, taken_d;
  logic            ready_q;
  logic            halted_q;
  logic            fault_q;

  logic [PC_W-1:0] stack_q [DEPTH];
  logic            push_en;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;

  op_e             op;
  logic [PC_W-1:0] pc_inc;
  logic            stack_full;
  logic            stack_empty;

  assign op          = op_e'(op_i);
  assign pc_inc      = pc_q + PC_W'(1);
  assign stack_full  = (sp_q == SP_W'(DEPTH));
  assign stack_empty = (sp_q == '0);
  assign push_idx    = IDX_W'(sp_q);
  assign top_idx     = IDX_W'(sp_q - SP_W'(1));

  // Next-state, next-PC and stack control
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    taken_d = 1'b0;
    push_en = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_i) begin
          state_d = ST_RUN;
          pc_d    = start_addr_i;
        end
      end

      ST_RUN: begin
        if (op_valid_i) begin
          case (op)
            OP_NEXT: pc_d = pc_inc;
            OP_JMP: begin
              pc_d    = jmp_address_i;
              taken_d = 1'b1;
            end
            OP_JMPZ, OP_JMPS, OP_JMPC: begin
              // Conditional jumps share one path; only the selected flag differs
              if ((op == OP_JMPZ && zero_flag_i) ||
                  (op == OP_JMPS && sign_flag_i) ||
                  (op == OP_JMPC && carry_flag_i)) begin
                pc_d    = jmp_address_i;
                taken_d = 1'b1;
              end else begin
                pc_d = pc_inc;
              end
            end
            OP_CALL: begin
              if (stack_full) begin
`ifdef PC_FLOW_STACK_GUARD_EN
                state_d = ST_FAULT;
`else
                // Return address is lost, control transfer still happens
                pc_d    = jmp_address_i;
                taken_d = 1'b1;
`endif
              end else begin
                push_en = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                pc_d    = jmp_address_i;
                taken_d = 1'b1;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
`ifdef PC_FLOW_STACK_GUARD_EN
                state_d = ST_FAULT;
`else
                pc_d    = '0;
                taken_d = 1'b1;
`endif
              end else begin
                pc_d    = stack_q[top_idx];
                sp_d    = sp_q - SP_W'(1);
                taken_d = 1'b1;
              end
            end
            OP_HALT: state_d = ST_HALT;
            default: pc_d = pc_q;
          endcase
        end
      end

`ifdef PC_FLOW_STACK_GUARD_EN
      ST_FAULT: state_d = ST_FAULT;
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  // Control and status registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      sp_q     <= '0;
      taken_q  <= 1'b0;
      ready_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      taken_q  <= taken_d;
      ready_q  <= (state_d == ST_RUN);
      halted_q <= (state_d == ST_HALT);
`ifdef PC_FLOW_STACK_GUARD_EN
      fault_q  <= (state_d == ST_FAULT);
`else
      fault_q  <= 1'b0;
`endif
    end
  end

  // Return-address storage; contents are don't-care after reset
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign op_ready_o = ready_q;
  assign pc_o       = pc_q;
  assign taken_o    = taken_q;
  assign halted_o   = halted_q;
  assign fault_o    = fault_q;
  assign sp_o       = sp_q;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed self-checking bench for pc_flow_ctrl.
module tb_pc_flow_ctrl;

  localparam logic [2:0] NEXT = 3'd0;
  localparam logic [2:0] JMP  = 3'd1;
  localparam logic [2:0] JMPZ = 3'd2;
  localparam logic [2:0] JMPS = 3'd3;
  localparam logic [2:0] JMPC = 3'd4;
  localparam logic [2:0] CALL = 3'd5;
  localparam logic [2:0] RET  = 3'd6;
  localparam logic [2:0] HALT = 3'd7;

  logic        clk;
  logic        rst;
  logic        start;
  logic [19:0] start_addr;
  logic        op_valid;
  logic [2:0]  op;
  logic        zero_flag;
  logic        sign_flag;
  logic        carry_flag;
  logic [19:0] jmp_address;
  logic        op_ready;
  logic [19:0] pc;
  logic        taken;
  logic        halted;
  logic        fault;
  logic [3:0]  sp;

  int checks = 0;
  int errors = 0;

  pc_flow_ctrl #(.PC_W(20), .DEPTH(8), .SP_W(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .start_addr_i  (start_addr),
    .op_valid_i    (op_valid),
    .op_i          (op),
    .zero_flag_i   (zero_flag),
    .sign_flag_i   (sign_flag),
    .carry_flag_i  (carry_flag),
    .jmp_address_i (jmp_address),
    .op_ready_o    (op_ready),
    .pc_o          (pc),
    .taken_o       (taken),
    .halted_o      (halted),
    .fault_o       (fault),
    .sp_o          (sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [19:0] a);
    op_valid    = v;
    op          = o;
    jmp_address = a;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0;
    op_valid = 1'b0; op = NEXT; jmp_address = '0;
    zero_flag = 1'b0; sign_flag = 1'b0; carry_flag = 1'b0;
    tick(); tick();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_sp", 32'(sp), 32'h0);
    chk("rst_taken", 32'(taken), 32'h0);
    chk("rst_ready", 32'(op_ready), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);

    // Boot and sequential execution
    rst = 1'b0; start = 1'b1; start_addr = 20'h00100;
    tick();
    start = 1'b0;
    chk("boot_pc", 32'(pc), 32'h00100);
    chk("boot_ready", 32'(op_ready), 32'h1);
    chk("boot_taken", 32'(taken), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, NEXT, 20'h0);
      tick();
      chk("next_pc", 32'(pc), 32'h00100 + 32'(i));
      chk("next_taken", 32'(taken), 32'h0);
    end

    // Jumps
    drive(1'b1, JMP, 20'h00200); tick();
    chk("jmp_pc", 32'(pc), 32'h00200);
    chk("jmp_taken", 32'(taken), 32'h1);
    sign_flag = 1'b1; drive(1'b1, JMPS, 20'h0ABCD); tick(); sign_flag = 1'b0;
    chk("jmps_pc", 32'(pc), 32'h0ABCD);
    chk("jmps_taken", 32'(taken), 32'h1);
    zero_flag = 1'b0; drive(1'b1, JMPZ, 20'h00050); tick();
    chk("jmpz_nt_pc", 32'(pc), 32'h0ABCE);
    chk("jmpz_nt_taken", 32'(taken), 32'h0);
    carry_flag = 1'b0; drive(1'b1, JMPC, 20'h00999); tick();
    chk("jmpc_nt_pc", 32'(pc), 32'h0ABCF);
    chk("jmpc_nt_taken", 32'(taken), 32'h0);
    carry_flag = 1'b1; drive(1'b1, JMPC, 20'h00010); tick(); carry_flag = 1'b0;
    chk("jmpc_pc", 32'(pc), 32'h00010);
    chk("jmpc_taken", 32'(taken), 32'h1);

    // Nested call / return
    drive(1'b1, CALL, 20'h00400); tick();
    chk("call1_pc", 32'(pc), 32'h00400);
    chk("call1_sp", 32'(sp), 32'h1);
    chk("call1_taken", 32'(taken), 32'h1);
    drive(1'b1, CALL, 20'h00800); tick();
    chk("call2_pc", 32'(pc), 32'h00800);
    chk("call2_sp", 32'(sp), 32'h2);
    drive(1'b1, RET, 20'h0); tick();
    chk("ret1_pc", 32'(pc), 32'h00401);
    chk("ret1_sp", 32'(sp), 32'h1);
    chk("ret1_taken", 32'(taken), 32'h1);
    drive(1'b1, RET, 20'h0); tick();
    chk("ret2_pc", 32'(pc), 32'h00011);
    chk("ret2_sp", 32'(sp), 32'h0);

    // Idle cycle holds
    drive(1'b0, JMP, 20'h12345); tick();
    chk("noop_pc", 32'(pc), 32'h00011);
    chk("noop_taken", 32'(taken), 32'h0);

    // Halt holds while ops keep arriving
    drive(1'b1, HALT, 20'h0); tick();
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_ready", 32'(op_ready), 32'h0);
    chk("halt_pc", 32'(pc), 32'h00011);
    chk("halt_taken", 32'(taken), 32'h0);
    drive(1'b1, NEXT, 20'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_hold_pc", 32'(pc), 32'h00011);
      chk("halt_hold_halted", 32'(halted), 32'h1);
    end

    // Restart from HALT at the top of memory, wrap on NEXT
    start = 1'b1; start_addr = 20'hFFFFF; tick(); start = 1'b0;
    chk("restart_pc", 32'(pc), 32'hFFFFF);
    chk("restart_ready", 32'(op_ready), 32'h1);
    chk("restart_halted", 32'(halted), 32'h0);
    drive(1'b1, NEXT, 20'h0); tick();
    chk("wrap_pc", 32'(pc), 32'h00000);
    drive(1'b1, HALT, 20'h0); tick();
    chk("halt2_halted", 32'(halted), 32'h1);
    drive(1'b0, NEXT, 20'h0);
    start = 1'b1; start_addr = 20'h00020; tick(); start = 1'b0;
    chk("restart2_pc", 32'(pc), 32'h00020);
    chk("restart2_sp", 32'(sp), 32'h0);

    // start in RUN is ignored
    start = 1'b1; start_addr = 20'h00777; drive(1'b1, NEXT, 20'h0); tick(); start = 1'b0;
    chk("start_in_run_pc", 32'(pc), 32'h00021);

    // Fill the stack
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, CALL, 20'h01000 + 20'(i)); tick();
      chk("fill_pc", 32'(pc), 32'h01000 + 32'(i));
      chk("fill_sp", 32'(sp), 32'(i + 1));
    end
    drive(1'b1, CALL, 20'h01234); tick();
`ifdef PC_FLOW_STACK_GUARD_EN
    chk("ovf_fault", 32'(fault), 32'h1);
    chk("ovf_pc", 32'(pc), 32'h01007);
    chk("ovf_sp", 32'(sp), 32'h8);
    chk("ovf_taken", 32'(taken), 32'h0);
    chk("ovf_ready", 32'(op_ready), 32'h0);
    drive(1'b0, NEXT, 20'h0); start = 1'b1; start_addr = 20'h00055; tick(); start = 1'b0;
    chk("fault_hold", 32'(fault), 32'h1);
    chk("fault_hold_pc", 32'(pc), 32'h01007);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("fault_rst", 32'(fault), 32'h0);
    start = 1'b1; start_addr = 20'h00300; tick(); start = 1'b0;
    drive(1'b1, RET, 20'h0); tick();
    chk("unf_fault", 32'(fault), 32'h1);
    chk("unf_pc", 32'(pc), 32'h00300);
    chk("unf_sp", 32'(sp), 32'h0);
    chk("unf_taken", 32'(taken), 32'h0);
`else
    chk("ovf_fault", 32'(fault), 32'h0);
    chk("ovf_pc", 32'(pc), 32'h01234);
    chk("ovf_sp", 32'(sp), 32'h8);
    chk("ovf_taken", 32'(taken), 32'h1);
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, RET, 20'h0); tick();
      chk("unwind_pc", 32'(pc), (j == 7) ? 32'h00022 : 32'h01007 - 32'(j));
      chk("unwind_sp", 32'(sp), 32'(7 - j));
    end
    drive(1'b1, RET, 20'h0); tick();
    chk("unf_pc", 32'(pc), 32'h00000);
    chk("unf_sp", 32'(sp), 32'h0);
    chk("unf_taken", 32'(taken), 32'h1);
    chk("unf_fault", 32'(fault), 32'h0);
`endif

    // Reset in the middle of activity
    drive(1'b0, NEXT, 20'h0);
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; start_addr = 20'h00040; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, CALL, 20'h00500 + 20'(i)); tick();
    end
    chk("pre_rst_sp", 32'(sp), 32'h3);
    chk("pre_rst_pc", 32'(pc), 32'h00502);
    rst = 1'b1; drive(1'b1, CALL, 20'h00999); tick();
    chk("mid_rst_pc", 32'(pc), 32'h0);
    chk("mid_rst_sp", 32'(sp), 32'h0);
    chk("mid_rst_taken", 32'(taken), 32'h0);
    chk("mid_rst_ready", 32'(op_ready), 32'h0);
    chk("mid_rst_halted", 32'(halted), 32'h0);
    rst = 1'b0; drive(1'b1, JMP, 20'h00888); tick();
    chk("idle_ignore_pc", 32'(pc), 32'h0);
    chk("idle_ignore_taken", 32'(taken), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
